// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: delay-line fill/run/drain,
// feedback mux select, twiddle address, and output framing.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   in_valid/in_sop - input sample strobe and frame-start qualifier
//   in_ready        - accept = in_valid & in_ready
//   flush           - request to drain after the current frame
//   fb_en, bf_sel   - delay-line shift enable and butterfly phase
//   tw_addr, tw_en  - twiddle ROM address and multiplier enable
//   out_valid/sop/eop, sop_err - output framing and error pulse
// Optional macro FFT_CTRL_STATS_EN adds saturating frame_cnt/err_cnt.
module fft_sdf_stage_ctrl #(
  parameter int FFT_LOG2 = 10,
  parameter int STAGE    = 0,
  parameter int TW_W     = FFT_LOG2 - 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sop,
  output logic            in_ready,
  input  logic            flush,
  output logic            fb_en,
  output logic            bf_sel,
  output logic [TW_W-1:0] tw_addr,
  output logic            tw_en,
  output logic            out_valid,
  output logic            out_sop,
  output logic            out_eop,
`ifdef FFT_CTRL_STATS_EN
  output logic [15:0]     frame_cnt,
  output logic [15:0]     err_cnt,
`endif
  output logic            sop_err
);

  localparam int N   = 1 << FFT_LOG2;
  localparam int DL  = FFT_LOG2 - 1 - STAGE;
  localparam int D   = 1 << DL;
  localparam int DCW = (DL > 0) ? DL : 1;

  localparam logic [FFT_LOG2-1:0] P_LAST = FFT_LOG2'(N - 1);
  localparam logic [FFT_LOG2-1:0] P_D    = FFT_LOG2'(D);
  localparam logic [FFT_LOG2-1:0] P_DM1  = FFT_LOG2'(D - 1);
  localparam logic [DCW-1:0]      DC_END = DCW'(D - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

  // With D=1 the frame-start sample already completes the fill.
  localparam state_t SOP_ST = (D == 1) ? S_RUN : S_FILL;

  state_t            state_q;
  logic [FFT_LOG2-1:0] cnt_q;
  logic [DCW-1:0]    drain_q;

  logic            accept;
  logic            resync;
  logic            pos_bf;
  logic [TW_W-1:0] tw_pos;
  logic [TW_W-1:0] tw_drain;

  assign in_ready = !rst && (state_q != S_DRAIN);
  assign accept   = in_valid && in_ready;
  assign resync   = in_sop && (cnt_q != '0);
  assign pos_bf   = cnt_q[DL];
  assign tw_pos   = TW_W'(cnt_q & P_DM1) << STAGE;
  assign tw_drain = TW_W'(drain_q) << STAGE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      fb_en     <= 1'b0;
      bf_sel    <= 1'b0;
      tw_addr   <= '0;
      tw_en     <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      sop_err   <= 1'b0;
    end else begin
      fb_en     <= 1'b0;
      bf_sel    <= 1'b0;
      tw_addr   <= '0;
      tw_en     <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      sop_err   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (in_sop) begin
              fb_en   <= 1'b1;
              cnt_q   <= FFT_LOG2'(1);
              state_q <= SOP_ST;
            end else begin
              sop_err <= 1'b1;
            end
          end
        end
        S_FILL, S_RUN: begin
          if (accept) begin
            if (resync) begin
              // Misplaced sop restarts the frame at this sample.
              sop_err <= 1'b1;
              fb_en   <= 1'b1;
              cnt_q   <= FFT_LOG2'(1);
              state_q <= SOP_ST;
            end else begin
              fb_en  <= 1'b1;
              bf_sel <= pos_bf;
              cnt_q  <= cnt_q + 1'b1;
              if (state_q == S_FILL) begin
                if (cnt_q == P_DM1) state_q <= S_RUN;
              end else begin
                out_valid <= 1'b1;
                tw_en     <= !pos_bf;
                tw_addr   <= pos_bf ? '0 : tw_pos;
                out_sop   <= (cnt_q == P_D);
                out_eop   <= (cnt_q == P_DM1);
                sop_err   <= !in_sop && (cnt_q == '0);
                if ((cnt_q == P_LAST) && flush) begin
                  state_q <= S_DRAIN;
                  drain_q <= '0;
                end
              end
            end
          end
        end
        S_DRAIN: begin
          // Shift out the last frame's tail with feedback selected.
          fb_en     <= 1'b1;
          out_valid <= 1'b1;
          tw_en     <= 1'b1;
          tw_addr   <= tw_drain;
          drain_q   <= drain_q + 1'b1;
          if (drain_q == DC_END) begin
            out_eop <= 1'b1;
            drain_q <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FFT_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (out_eop && (frame_cnt != 16'hFFFF))
        frame_cnt <= frame_cnt + 16'd1;
      if (sop_err && (err_cnt != 16'hFFFF))
        err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
